// File: rtl/matvec_mul.sv
// Fully-connected layer stage: y = W*x over synchronous input/weight memories,
// one MAC every two cycles, saturated 32-bit results written by row index.
module matvec_mul #(
  parameter int FRAC_BITS = 0,
  parameter int ACC_W     = 74
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [9:0]  m,
  input  logic [9:0]  n,
  output logic [15:0] input_addr,
  input  logic [31:0] input_data,
  output logic [15:0] weight_addr,
  input  logic [31:0] weight_data,
  output logic [15:0] output_addr,
  output logic [31:0] output_data,
  output logic        write_enable,
  output logic        done
);

  // state  | meaning
  // IDLE   | waiting for start, outputs held
  // WAIT   | one cycle of memory read latency
  // MAC    | accumulate input_data*weight_data, advance column
  // STORE  | write saturated row result, advance row
  // FINISH | raise done, return to IDLE
  typedef enum logic [2:0] {IDLE, WAIT, MAC, STORE, FINISH} state_t;

  state_t                   state;
  logic [9:0]               m_l, n_l;
  logic [9:0]               row, col;
  logic signed [ACC_W-1:0]  acc;

  logic signed [63:0]       prod;
  logic signed [ACC_W-1:0]  acc_sum;
  logic signed [ACC_W-1:0]  shifted;
  logic [ACC_W-32:0]        upper;
  logic [31:0]              sat;

  always_comb begin
    prod    = $signed({{32{input_data[31]}}, input_data}) *
              $signed({{32{weight_data[31]}}, weight_data});
    acc_sum = acc + $signed({{(ACC_W-64){prod[63]}}, prod});
    shifted = acc >>> FRAC_BITS;
    upper   = shifted[ACC_W-1:31];
    // In range only when every bit above bit 30 matches the sign
    if (upper == '0 || upper == '1)
      sat = shifted[31:0];
    else if (shifted[ACC_W-1])
      sat = 32'h8000_0000;
    else
      sat = 32'h7FFF_FFFF;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      m_l          <= '0;
      n_l          <= '0;
      row          <= '0;
      col          <= '0;
      acc          <= '0;
      input_addr   <= '0;
      weight_addr  <= '0;
      output_addr  <= '0;
      output_data  <= '0;
      write_enable <= 1'b0;
      done         <= 1'b0;
    end else begin
      write_enable <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            m_l         <= m;
            n_l         <= n;
            row         <= '0;
            col         <= '0;
            acc         <= '0;
            input_addr  <= '0;
            weight_addr <= '0;
            done        <= 1'b0;
            state       <= (m == 10'd0 || n == 10'd0) ? FINISH : WAIT;
          end
        end
        WAIT: state <= MAC;
        MAC: begin
          acc <= acc_sum;
          if (col == n_l - 10'd1) begin
            state <= STORE;
          end else begin
            col         <= col + 10'd1;
            input_addr  <= input_addr + 16'd1;
            weight_addr <= weight_addr + 16'd1;
            state       <= WAIT;
          end
        end
        STORE: begin
          output_addr  <= {6'd0, row};
          output_data  <= sat;
          write_enable <= 1'b1;
          acc          <= '0;
          if (row == m_l - 10'd1) begin
            state <= FINISH;
          end else begin
            row         <= row + 10'd1;
            col         <= '0;
            input_addr  <= '0;
            weight_addr <= weight_addr + 16'd1;
            state       <= WAIT;
          end
        end
        FINISH: begin
          done  <= 1'b1;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_matvec_mul.sv
// Directed bench for matvec_mul: integer instance plus a FRAC_BITS=16 instance.
module tb_matvec_mul;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int n_pass = 0;
  int n_total = 0;

  // integer instance
  logic        start0 = 1'b0;
  logic [9:0]  m0 = '0, n0 = '0;
  logic [15:0] input_addr0, weight_addr0, output_addr0;
  logic [31:0] input_data0, weight_data0, output_data0;
  logic        write_enable0, done0;
  logic [31:0] xmem0 [0:63];
  logic [31:0] wmem0 [0:63];
  logic [31:0] out0  [0:63];
  int          wr_cnt0 = 0;
  logic        wlog_en0 = 1'b0;
  logic [15:0] wlog0 [$];

  // fixed-point instance
  logic        start1 = 1'b0;
  logic [9:0]  m1 = '0, n1 = '0;
  logic [15:0] input_addr1, weight_addr1, output_addr1;
  logic [31:0] input_data1, weight_data1, output_data1;
  logic        write_enable1, done1;
  logic [31:0] xmem1 [0:63];
  logic [31:0] wmem1 [0:63];
  logic [31:0] out1  [0:63];
  int          wr_cnt1 = 0;

  matvec_mul #(.FRAC_BITS(0), .ACC_W(74)) dut0 (
    .clk(clk), .rst_n(rst_n), .start(start0), .m(m0), .n(n0),
    .input_addr(input_addr0), .input_data(input_data0),
    .weight_addr(weight_addr0), .weight_data(weight_data0),
    .output_addr(output_addr0), .output_data(output_data0),
    .write_enable(write_enable0), .done(done0));

  matvec_mul #(.FRAC_BITS(16), .ACC_W(74)) dut1 (
    .clk(clk), .rst_n(rst_n), .start(start1), .m(m1), .n(n1),
    .input_addr(input_addr1), .input_data(input_data1),
    .weight_addr(weight_addr1), .weight_data(weight_data1),
    .output_addr(output_addr1), .output_data(output_data1),
    .write_enable(write_enable1), .done(done1));

  always @(posedge clk) begin
    input_data0  <= xmem0[input_addr0[5:0]];
    weight_data0 <= wmem0[weight_addr0[5:0]];
    input_data1  <= xmem1[input_addr1[5:0]];
    weight_data1 <= wmem1[weight_addr1[5:0]];
  end

  always @(negedge clk) begin
    if (write_enable0) begin
      out0[output_addr0[5:0]] = output_data0;
      wr_cnt0++;
    end
    if (write_enable1) begin
      out1[output_addr1[5:0]] = output_data1;
      wr_cnt1++;
    end
    if (wlog_en0 && (wlog0.size() == 0 || wlog0[$] != weight_addr0))
      wlog0.push_back(weight_addr0);
  end

  task automatic clear_mem();
    for (int i = 0; i < 64; i++) begin
      xmem0[i] = '0; wmem0[i] = '0; out0[i] = 32'hDEADBEEF;
      xmem1[i] = '0; wmem1[i] = '0; out1[i] = 32'hDEADBEEF;
    end
  endtask

  task automatic load_scn1();
    clear_mem();
    xmem0[0] = 1; xmem0[1] = 2; xmem0[2] = 3;
    wmem0[0] = 1; wmem0[1] = 0; wmem0[2] = -1;
    wmem0[3] = 2; wmem0[4] = 2; wmem0[5] = 2;
  endtask

  // Start dut0, optionally pulse start again glitch_at cycles later, wait for done.
  task automatic run0(input logic [9:0] mm, input logic [9:0] nn, input int glitch_at,
                      output int cycles, output logic done_at_accept);
    @(negedge clk);
    m0 = mm; n0 = nn; start0 = 1'b1;
    wr_cnt0 = 0;
    wlog0.delete();
    @(posedge clk); #1;
    start0 = 1'b0;
    done_at_accept = done0;
    m0 = 10'h3FF; n0 = 10'h3FF;
    wlog_en0 = 1'b1;
    cycles = 0;
    while (!done0 && cycles < 1000) begin
      @(posedge clk); #1;
      cycles++;
      if (cycles == glitch_at) begin
        start0 = 1'b1; m0 = 10'd1; n0 = 10'd1;
      end else begin
        start0 = 1'b0;
      end
    end
    start0 = 1'b0;
    wlog_en0 = 1'b0;
    n_total++;
    if (!done0) $display("FAIL run0_timeout: done=%0b after %0d cycles, required 1", done0, cycles);
    else n_pass++;
  endtask

  task automatic run1(output int cycles);
    @(negedge clk);
    m1 = 10'd1; n1 = 10'd1; start1 = 1'b1;
    wr_cnt1 = 0;
    @(posedge clk); #1;
    start1 = 1'b0;
    cycles = 0;
    while (!done1 && cycles < 1000) begin
      @(posedge clk); #1;
      cycles++;
    end
    n_total++;
    if (!done1) $display("FAIL run1_timeout: done=%0b after %0d cycles, required 1", done1, cycles);
    else n_pass++;
  endtask

  task automatic test_reset();
    logic [15:0] zero16 = 16'd0;
    #1;
    n_total++; if (input_addr0 !== zero16) $display("FAIL reset_input_addr: got %h want 0", input_addr0); else n_pass++;
    n_total++; if (weight_addr0 !== zero16) $display("FAIL reset_weight_addr: got %h want 0", weight_addr0); else n_pass++;
    n_total++; if (output_addr0 !== zero16) $display("FAIL reset_output_addr: got %h want 0", output_addr0); else n_pass++;
    n_total++; if (output_data0 !== 32'd0) $display("FAIL reset_output_data: got %h want 0", output_data0); else n_pass++;
    n_total++; if (write_enable0 !== 1'b0) $display("FAIL reset_we: got %b want 0", write_enable0); else n_pass++;
    n_total++; if (done0 !== 1'b0 || done1 !== 1'b0) $display("FAIL reset_done: got %b%b want 00", done0, done1); else n_pass++;
    @(negedge clk); rst_n = 1'b1;
  endtask

  task automatic test_basic();
    int cyc; logic dacc;
    logic [15:0] exp_w [6] = '{16'd0, 16'd1, 16'd2, 16'd3, 16'd4, 16'd5};
    load_scn1();
    run0(10'd2, 10'd3, -1, cyc, dacc);
    n_total++; if (out0[0] !== 32'hFFFFFFFE) $display("FAIL basic_row0: got %h want fffffffe", out0[0]); else n_pass++;
    n_total++; if (out0[1] !== 32'd12) $display("FAIL basic_row1: got %h want 0000000c", out0[1]); else n_pass++;
    n_total++; if (wr_cnt0 != 2) $display("FAIL basic_writes: got %0d want 2", wr_cnt0); else n_pass++;
    n_total++; if (cyc != 15) $display("FAIL basic_latency: got %0d want 15", cyc); else n_pass++;
    n_total++;
    if (wlog0.size() != 6) $display("FAIL basic_waddr_len: got %0d want 6", wlog0.size());
    else begin
      int bad = 0;
      for (int i = 0; i < 6; i++) if (wlog0[i] !== exp_w[i]) bad++;
      if (bad != 0) $display("FAIL basic_waddr_seq: %0d entries differ from 0..5", bad);
      else n_pass++;
    end
    n_total++; if (write_enable0 !== 1'b0) $display("FAIL basic_we_idle: got %b want 0", write_enable0); else n_pass++;
  endtask

  task automatic test_saturation();
    int cyc; logic dacc;
    clear_mem();
    xmem0[0] = 32'h40000000; xmem0[1] = 32'h40000000;
    wmem0[0] = 4; wmem0[1] = 4; wmem0[2] = -4; wmem0[3] = -4;
    run0(10'd2, 10'd2, -1, cyc, dacc);
    n_total++; if (out0[0] !== 32'h7FFFFFFF) $display("FAIL sat_pos: got %h want 7fffffff", out0[0]); else n_pass++;
    n_total++; if (out0[1] !== 32'h80000000) $display("FAIL sat_neg: got %h want 80000000", out0[1]); else n_pass++;
    n_total++; if (cyc != 11) $display("FAIL sat_latency: got %0d want 11", cyc); else n_pass++;
  endtask

  task automatic test_zero_dims();
    int cyc; logic dacc;
    run0(10'd0, 10'd5, -1, cyc, dacc);
    n_total++; if (cyc != 1) $display("FAIL zero_m_latency: got %0d want 1", cyc); else n_pass++;
    n_total++; if (wr_cnt0 != 0) $display("FAIL zero_m_writes: got %0d want 0", wr_cnt0); else n_pass++;
    run0(10'd3, 10'd0, -1, cyc, dacc);
    n_total++; if (cyc != 1) $display("FAIL zero_n_latency: got %0d want 1", cyc); else n_pass++;
    n_total++; if (wr_cnt0 != 0) $display("FAIL zero_n_writes: got %0d want 0", wr_cnt0); else n_pass++;
  endtask

  task automatic test_reset_mid();
    int cyc; logic dacc;
    load_scn1();
    @(negedge clk);
    m0 = 10'd2; n0 = 10'd3; start0 = 1'b1; wr_cnt0 = 0;
    @(posedge clk); #1; start0 = 1'b0;
    // after 9 more edges the DUT is in row 1, between its first and second MAC
    repeat (9) @(posedge clk);
    #3; rst_n = 1'b0; #1;
    n_total++; if (write_enable0 !== 1'b0 || done0 !== 1'b0) $display("FAIL midrst_we_done: got we=%b done=%b want 0 0", write_enable0, done0); else n_pass++;
    n_total++; if ({input_addr0, weight_addr0, output_addr0} !== 48'd0) $display("FAIL midrst_addrs: got %h %h %h want 0 0 0", input_addr0, weight_addr0, output_addr0); else n_pass++;
    n_total++; if (wr_cnt0 != 1) $display("FAIL midrst_partial_writes: got %0d want 1", wr_cnt0); else n_pass++;
    @(negedge clk); rst_n = 1'b1;
    load_scn1();
    run0(10'd2, 10'd3, -1, cyc, dacc);
    n_total++; if (out0[0] !== 32'hFFFFFFFE || out0[1] !== 32'd12) $display("FAIL midrst_rerun: got %h %h want fffffffe 0000000c", out0[0], out0[1]); else n_pass++;
    n_total++; if (wr_cnt0 != 2 || cyc != 15) $display("FAIL midrst_rerun_timing: got writes=%0d cycles=%0d want 2 15", wr_cnt0, cyc); else n_pass++;
  endtask

  task automatic test_back_to_back();
    int cyc; logic dacc;
    load_scn1();
    run0(10'd2, 10'd3, 5, cyc, dacc);
    n_total++; if (wr_cnt0 != 2 || cyc != 15) $display("FAIL busy_start: got writes=%0d cycles=%0d want 2 15", wr_cnt0, cyc); else n_pass++;
    n_total++; if (out0[0] !== 32'hFFFFFFFE || out0[1] !== 32'd12) $display("FAIL busy_results: got %h %h want fffffffe 0000000c", out0[0], out0[1]); else n_pass++;
    repeat (5) @(posedge clk);
    #1;
    n_total++; if (done0 !== 1'b1) $display("FAIL done_hold: got %b want 1", done0); else n_pass++;
    clear_mem();
    xmem0[0] = -7; wmem0[0] = 3;
    run0(10'd1, 10'd1, -1, cyc, dacc);
    n_total++; if (dacc !== 1'b0) $display("FAIL done_drop: got %b want 0", dacc); else n_pass++;
    n_total++; if (out0[0] !== 32'hFFFFFFEB) $display("FAIL second_run: got %h want ffffffeb", out0[0]); else n_pass++;
    n_total++; if (cyc != 4 || wr_cnt0 != 1) $display("FAIL second_timing: got cycles=%0d writes=%0d want 4 1", cyc, wr_cnt0); else n_pass++;
  endtask

  task automatic test_frac();
    int cyc;
    clear_mem();
    xmem1[0] = 32'h00018000; wmem1[0] = 32'h00020000;
    run1(cyc);
    n_total++; if (out1[0] !== 32'h00030000) $display("FAIL frac_mul: got %h want 00030000", out1[0]); else n_pass++;
    n_total++; if (cyc != 4 || wr_cnt1 != 1) $display("FAIL frac_timing: got cycles=%0d writes=%0d want 4 1", cyc, wr_cnt1); else n_pass++;
    clear_mem();
    xmem1[0] = 32'hFFFFFFFF; wmem1[0] = 32'h00008000;
    run1(cyc);
    n_total++; if (out1[0] !== 32'hFFFFFFFF) $display("FAIL frac_floor: got %h want ffffffff", out1[0]); else n_pass++;
  endtask

  initial begin
    clear_mem();
    test_reset();
    test_basic();
    test_saturation();
    test_zero_dims();
    test_reset_mid();
    test_back_to_back();
    test_frac();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation exceeded time limit");
    $fatal(1);
  end
endmodule
